// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential unsigned WIDTH x WIDTH multiplier controller.
// It walks an external combinational 2x2 multiplier cell over every pair of
// 2-bit operand digits and shift-accumulates the 4-bit partial products.
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [1:0]         pp_a,
  output logic [1:0]         pp_b,
  input  logic [3:0]         pp_c,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    term;
  logic [PW-1:0]    sum;
  logic [IW-1:0]    i, j;
  logic [IW+1:0]    shamt;
  logic             last;

  // The digit pair (i, j) carries weight 4^(i+j), i.e. a shift of 2*(i+j).
  assign last  = (i == LAST_IDX) && (j == LAST_IDX);
  assign shamt = {(IW + 1)'(i) + (IW + 1)'(j), 1'b0};
  assign term  = PW'(pp_c) << shamt;
  assign sum   = acc + term;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs; digits are only driven in RUN.
  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    pp_a        = 2'b00;
    pp_b        = 2'b00;
    case (state)
      IDLE: begin
        start_ready = !rst;
        if (start_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        pp_a = a_reg[{i, 1'b0} +: 2];
        pp_b = b_reg[{j, 1'b0} +: 2];
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, digit counters (j inner, i outer) and the accumulator.
  // The final partial product is folded straight into res on the last RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      res   <= '0;
      i     <= '0;
      j     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          if (j == LAST_IDX) begin
            j <= '0;
            i <= i + IW'(1);
          end else begin
            j <= j + IW'(1);
          end
          if (last) begin
            res <= sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential unsigned WIDTH×WIDTH multiplier controller that builds a full product from 2-bit × 2-bit partial products, one per clock. It sits directly around the team's combinational 2×2 array multiplier cell: it feeds that cell's operands, consumes its 4-bit product and shift-accumulates the results. Operands enter and the product leaves through valid/ready handshakes.

## Interface
- WIDTH, 8, operand width in bits; even, ≥2; N = WIDTH/2 digits, N·N RUN cycles per operation
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- start_valid  in  1  operands present on a_in/b_in
- start_ready  out  1  block can accept operands (IDLE and rst low)
- a_in  in  WIDTH  multiplicand, unsigned
- b_in  in  WIDTH  multiplier, unsigned
- pp_a  out  2  operand digit to the 2×2 cell
- pp_b  out  2  operand digit to the 2×2 cell
- pp_c  in  4  product from the 2×2 cell (pp_a·pp_b, combinational, same cycle)
- res_valid  out  1  res holds a completed product
- res_ready  in  1  consumer takes res
- res  out  2·WIDTH  unsigned product a·b

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1 while rst is low.
  - On start_valid: latch a_reg=a_in and b_reg=b_in, clear acc, set i=0 and j=0, go to RUN.
- RUN, one partial product per cycle:
  - pp_a=a_reg[2i+1:2i], pp_b=b_reg[2j+1:2j].
  - acc ← acc + (pp_c << 2(i+j)).
  - j increments; when j=N-1 it wraps to 0 and i increments.
  - The cycle with i=j=N-1 is the last. It loads res ← final acc (including that last term) and goes to DONE.
- DONE:
  - res_valid=1; res is held stable.
  - When res_valid and res_ready are both high: go to IDLE at that edge.
- pp_a=pp_b=0 in IDLE and DONE.
- Width rules:
  - acc and res are 2·WIDTH bits; the maximum product fits, so no overflow or truncation.
  - Each shifted term is zero-extended to 2·WIDTH bits before the add.
- pp_c is trusted as-is; the block does not check it.
- start_valid outside IDLE is ignored and operands are not sampled (start_ready=0).
- Reset, synchronous, at any point including mid-RUN or DONE:
  - state=IDLE, acc=0, res=0, res_valid=0, i=j=0.
  - The aborted operation produces no result.
  - start_ready=0 during the rst-high cycle and 1 the cycle after.

## Timing
- Accept handshake at edge E0. RUN occupies the cycles ending at edges E0+1 … E0+N².
- res_valid rises after edge E0+N² (16 cycles for WIDTH=8, 1 for WIDTH=2).
- res_ready sampled high in the first DONE cycle → IDLE next cycle, with start_ready=1 there; no same-cycle bypass from DONE to RUN.
- Minimum initiation interval: N²+2 cycles.
- All outputs registered or decoded from state, except pp_a/pp_b, which are muxed from registers (a_reg/b_reg, i, j).
- Combinational path pp_a/pp_b → external cell → pp_c → adder must close in one cycle.
- No combinational path from res_ready or start_valid to any output.

## Test plan
- a=0xFF, b=0xFF, res_ready=1 → res_valid exactly 16 cycles after accept, res=0xFE01; start_ready=1 one cycle later.
- a=0x00, b=0xA5 → res=0x0000; a=0x01, b=0x01 → res=0x0001.
- a=0xE4, b=0x01 → pp_a sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3 and pp_b sequence 1,0,0,0 repeating; res=0x00E4.
- a=0x12, b=0x34 with res_ready low 5 cycles in DONE → res=0x03A8 held stable throughout; start_valid with a=0x77 during RUN/DONE is not accepted.
- rst high at RUN cycle 7 → next cycle IDLE, res_valid=0, res=0; then a=0xC3, b=0x3C → res=0x2DB4.
- WIDTH=2: a=3, b=3 → 1 RUN cycle, res=0x9.
- Random regression: 1000 operand pairs, back-to-back, random res_ready stalls → every res equals a·b, no dropped or duplicated results.
